// File: rtl/sample_frame_requester.sv
// rtl/sample_frame_requester.sv - request/receive of a labelled 16-bit sample frame over a byte UART
//
// Sends REQ_BYTE to a remote responder, waits for the transmitter to go busy and
// return idle, then receives a 3-byte frame {label, LSB, MSB}.
// Optional receive timeout: define SAMPLE_FRAME_TIMEOUT_EN.
//
// Ports:
//   clk, reset_b          clock, asynchronous active-low reset
//   start                 one-cycle request strobe (honoured only in IDLE)
//   tx_ready/tx_send/tx_data   UART transmitter handshake
//   rx_ready/rx_data      UART receiver byte strobe and data
//   busy                  high whenever not IDLE
//   sample/channel        last good frame, updated with sample_valid
//   sample_valid, frame_error, timeout   one-cycle result strobes
module sample_frame_requester #(
    parameter logic [7:0] LABEL_BASE     = 8'h30,
    parameter int         NUM_CH         = 4,
    parameter logic [7:0] REQ_BYTE       = 8'h41,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        start,
    input  logic        tx_ready,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        busy,
    output logic [15:0] sample,
    output logic [1:0]  channel,
    output logic        sample_valid,
    output logic        frame_error,
    output logic        timeout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_SEND,
        ST_REQ_WAIT_LO,
        ST_REQ_WAIT_HI,
        ST_RX_LABEL,
        ST_RX_LSB,
        ST_RX_MSB
    } state_t;

    // Label range compared on 9 bits so LABEL_BASE+NUM_CH cannot wrap.
    localparam logic [8:0] LBL_LO = 9'(LABEL_BASE);
    localparam logic [8:0] LBL_HI = 9'(int'(LABEL_BASE) + NUM_CH);

    state_t      state_q;
    logic [1:0]  chan_pend_q;
    logic [7:0]  lsb_q;
    logic [15:0] sample_q;
    logic [1:0]  channel_q;
    logic        sample_valid_q;
    logic        frame_error_q;
    logic        label_ok;
    logic [1:0]  label_idx;
    logic        in_rx;

    assign label_ok  = ({1'b0, rx_data} >= LBL_LO) && ({1'b0, rx_data} < LBL_HI);
    // Low two bits of (rx_data - LABEL_BASE) depend only on the low two bits of each.
    assign label_idx = rx_data[1:0] - LABEL_BASE[1:0];
    assign in_rx     = (state_q == ST_RX_LABEL) || (state_q == ST_RX_LSB) ||
                       (state_q == ST_RX_MSB);

`ifdef SAMPLE_FRAME_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             timeout_q;
    logic             tmo_hit;

    // An accepted byte in the same cycle wins over the timeout.
    assign tmo_hit = in_rx && !rx_ready && (tmo_cnt_q == CNT_LAST);
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q        <= ST_IDLE;
            chan_pend_q    <= 2'd0;
            lsb_q          <= 8'd0;
            sample_q       <= 16'd0;
            channel_q      <= 2'd0;
            sample_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
`ifdef SAMPLE_FRAME_TIMEOUT_EN
            tmo_cnt_q      <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            sample_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
`ifdef SAMPLE_FRAME_TIMEOUT_EN
            timeout_q      <= 1'b0;
            if (in_rx) begin
                if (rx_ready) begin
                    tmo_cnt_q <= '0;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                end
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_REQ_SEND;
                    end
                end
                ST_REQ_SEND: begin
                    if (tx_ready) begin
                        state_q <= ST_REQ_WAIT_LO;
                    end
                end
                // Wait for the transmitter to take the byte, then to finish it.
                ST_REQ_WAIT_LO: begin
                    if (!tx_ready) begin
                        state_q <= ST_REQ_WAIT_HI;
                    end
                end
                ST_REQ_WAIT_HI: begin
                    if (tx_ready) begin
                        state_q <= ST_RX_LABEL;
`ifdef SAMPLE_FRAME_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                ST_RX_LABEL: begin
                    if (rx_ready) begin
                        if (label_ok) begin
                            chan_pend_q <= label_idx;
                            state_q     <= ST_RX_LSB;
                        end else begin
                            frame_error_q <= 1'b1;
                            state_q       <= ST_IDLE;
                        end
                    end
                end
                ST_RX_LSB: begin
                    if (rx_ready) begin
                        lsb_q   <= rx_data;
                        state_q <= ST_RX_MSB;
                    end
                end
                ST_RX_MSB: begin
                    if (rx_ready) begin
                        sample_q       <= {rx_data, lsb_q};
                        channel_q      <= chan_pend_q;
                        sample_valid_q <= 1'b1;
                        state_q        <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
`ifdef SAMPLE_FRAME_TIMEOUT_EN
            if (tmo_hit) begin
                timeout_q <= 1'b1;
                state_q   <= ST_IDLE;
            end
`endif
        end
    end

    assign tx_data      = REQ_BYTE;
    assign tx_send      = (state_q == ST_REQ_SEND) && tx_ready;
    assign busy         = (state_q != ST_IDLE);
    assign sample       = sample_q;
    assign channel      = channel_q;
    assign sample_valid = sample_valid_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_sample_frame_requester.sv
// tb/tb_sample_frame_requester.sv - directed self-checking bench for sample_frame_requester
module tb_sample_frame_requester;

    logic        clk;
    logic        reset_b;
    logic        start;
    logic        tx_ready;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        busy;
    logic [15:0] sample;
    logic [1:0]  channel;
    logic        sample_valid;
    logic        frame_error;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;
    int tx_cnt   = 0;

    sample_frame_requester #(
        .LABEL_BASE     (8'h30),
        .NUM_CH         (4),
        .REQ_BYTE       (8'h41),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .start        (start),
        .tx_ready     (tx_ready),
        .tx_send      (tx_send),
        .tx_data      (tx_data),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .busy         (busy),
        .sample       (sample),
        .channel      (channel),
        .sample_valid (sample_valid),
        .frame_error  (frame_error),
        .timeout      (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change 2 time units after the rising edge, so the falling edge sees stable values.
    always @(negedge clk) begin
        if (tx_send) tx_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    // From IDLE with tx_ready=1: issue start, run the transmitter handshake, end in RX_LABEL.
    task automatic do_request();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("req_tx_send", tx_send, 1'b1);
        check("req_tx_data", tx_data, 8'h41);
        tick();
        tx_ready = 1'b0;
        check("req_tx_send_once", tx_send, 1'b0);
        tick();
        tick();
        tx_ready = 1'b1;
        tick();
        check("req_busy", busy, 1'b1);
    endtask

    initial begin
        reset_b  = 1'b0;
        start    = 1'b0;
        tx_ready = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_tx_send", tx_send, 1'b0);
        check("rst_sample", sample, 16'h0000);
        check("rst_channel", channel, 2'd0);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_ferr", frame_error, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_tx_data", tx_data, 8'h41);
        tick();
        tick();
        reset_b  = 1'b1;
        tx_ready = 1'b1;
        tick();
        check("idle_busy", busy, 1'b0);

        // Basic frame: label 0x32, 0x34, 0x12
        do_request();
        send_byte(8'h32);
        send_byte(8'h34);
        check("f1_no_early_valid", sample_valid, 1'b0);
        send_byte(8'h12);
        check("f1_valid", sample_valid, 1'b1);
        check("f1_sample", sample, 16'h1234);
        check("f1_channel", channel, 2'd2);
        check("f1_busy", busy, 1'b0);
        tick();
        check("f1_valid_one_cycle", sample_valid, 1'b0);
        check("f1_sample_hold", sample, 16'h1234);
        check("f1_tx_cnt", tx_cnt, 1);

        // start held while transmitter busy; extra starts mid-frame and at frame end
        tx_ready = 1'b0;
        start    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_no_tx_send", tx_send, 1'b0);
        end
        check("hold_busy", busy, 1'b1);
        tx_ready = 1'b1;
        #1;
        check("hold_tx_send", tx_send, 1'b1);
        tick();
        tx_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tx_ready = 1'b1;
        tick();
        send_byte(8'h33);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h00);
        start = 1'b1;
        send_byte(8'h80);
        start = 1'b0;
        check("f2_valid", sample_valid, 1'b1);
        check("f2_sample", sample, 16'h8000);
        check("f2_channel", channel, 2'd3);
        check("f2_busy", busy, 1'b0);
        tick();
        check("f2_end_start_ignored", busy, 1'b0);
        tick();
        check("f2_tx_cnt", tx_cnt, 2);

        // Invalid label
        do_request();
        send_byte(8'h39);
        check("ferr_pulse", frame_error, 1'b1);
        check("ferr_no_valid", sample_valid, 1'b0);
        check("ferr_busy", busy, 1'b0);
        check("ferr_sample", sample, 16'h8000);
        check("ferr_channel", channel, 2'd3);
        send_byte(8'h00);
        check("ferr_one_cycle", frame_error, 1'b0);
        send_byte(8'h00);
        tick();
        check("ferr_ignored_valid", sample_valid, 1'b0);
        check("ferr_ignored_busy", busy, 1'b0);
        check("ferr_ignored_sample", sample, 16'h8000);

        // Receive timeout after the label only
        do_request();
        send_byte(8'h30);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("tmo_not_yet", timeout, 1'b0);
        end
        tick();
`ifdef SAMPLE_FRAME_TIMEOUT_EN
        check("tmo_pulse", timeout, 1'b1);
        check("tmo_busy", busy, 1'b0);
        check("tmo_no_valid", sample_valid, 1'b0);
        tick();
        check("tmo_one_cycle", timeout, 1'b0);
        check("tmo_sample", sample, 16'h8000);
`else
        check("tmo_off", timeout, 1'b0);
        check("tmo_off_busy", busy, 1'b1);
        repeat (20) tick();
        check("tmo_off_busy_late", busy, 1'b1);
        reset_b = 1'b0;
        tick();
        reset_b = 1'b1;
        tick();
`endif
        check("tmo_tx_cnt", tx_cnt, 4);

        // Reset after the LSB byte
        do_request();
        send_byte(8'h32);
        send_byte(8'h55);
        reset_b = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_sample", sample, 16'h0000);
        check("mid_rst_channel", channel, 2'd0);
        check("mid_rst_valid", sample_valid, 1'b0);
        tick();
        reset_b = 1'b1;
        send_byte(8'h66);
        tick();
        check("post_rst_idle", busy, 1'b0);
        check("post_rst_no_valid", sample_valid, 1'b0);
        do_request();
        send_byte(8'h31);
        send_byte(8'hFF);
        send_byte(8'h7F);
        check("f3_valid", sample_valid, 1'b1);
        check("f3_sample", sample, 16'h7FFF);
        check("f3_channel", channel, 2'd1);
        tick();
        check("f3_tx_cnt", tx_cnt, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
